// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared I2C target state encoding and protocol constants
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_SUB,
    ST_SUB_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_MACK,
    ST_IGNORE
  } i2c_state_t;

  localparam int         RW_BIT        = 0;
  localparam logic [6:0] GEN_CALL_ADDR = 7'h00;
  localparam logic [3:0] BYTE_DONE     = 4'd8;

endpackage

// File: rtl/i2c_cond_detect.sv
// rtl/i2c_cond_detect.sv - SCL/SDA synchroniser with START/STOP and SCL edge events
module i2c_cond_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_s,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  // [0],[1] form the synchroniser, [2] is the history stage
  logic [2:0] scl_q, scl_d;
  logic [2:0] sda_q, sda_d;

  always_comb begin
    scl_d = {scl_q[1:0], scl_i};
    sda_d = {sda_q[1:0], sda_i};
  end

  // Reset to the idle-bus level so leaving reset never fakes a START
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_q <= 3'b111;
      sda_q <= 3'b111;
    end else begin
      scl_q <= scl_d;
      sda_q <= sda_d;
    end
  end

  assign sda_s     = sda_q[1];
  assign scl_rise  =  scl_q[1] & ~scl_q[2];
  assign scl_fall  = ~scl_q[1] &  scl_q[2];
  assign start_det =  scl_q[1] &  scl_q[2] &  sda_q[2] & ~sda_q[1];
  assign stop_det  =  scl_q[1] &  scl_q[2] & ~sda_q[2] &  sda_q[1];

endmodule

// File: rtl/i2c_target_regs.sv
// rtl/i2c_target_regs.sv - I2C target bridging bus transfers onto a byte-wide register port
module i2c_target_regs
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = 7'h70,
  parameter int         NREGS    = 8,
  parameter int         AW       = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          scl_i,
  input  logic          sda_i,
  output logic          sda_oe,
  output logic          wr_stb,
  output logic [AW-1:0] wr_addr,
  output logic [7:0]    wr_data,
  output logic [AW-1:0] rd_addr,
  input  logic [7:0]    rd_data,
  output logic          busy
);

  logic sda_s, scl_rise, scl_fall, start_det, stop_det;

  i2c_cond_detect u_cond (
    .clk       (clk),
    .rst_n     (rst_n),
    .scl_i     (scl_i),
    .sda_i     (sda_i),
    .sda_s     (sda_s),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  i2c_state_t    state_q, state_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic          rw_q, rw_d;
  logic          sda_oe_q, sda_oe_d;
  logic          busy_q, busy_d;
  logic          wr_stb_q, wr_stb_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]    wr_data_q, wr_data_d;
  logic          addr_hit;

  assign addr_hit = (shift_q[7:1] == DEV_ADDR) && (shift_q[7:1] != GEN_CALL_ADDR);

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    ptr_d     = ptr_q;
    rw_d      = rw_q;
    sda_oe_d  = sda_oe_q;
    busy_d    = busy_q;
    wr_stb_d  = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;

    if (start_det) begin
      state_d   = ST_ADDR;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
    end else if (stop_det) begin
      state_d   = ST_IDLE;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
    end else if (scl_rise) begin
      case (state_q)
        ST_ADDR, ST_SUB, ST_WDATA: begin
          if (bit_cnt_q != BYTE_DONE) begin
            shift_d   = {shift_q[6:0], sda_s};
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              if (state_q == ST_SUB) ptr_d = shift_d[AW-1:0];
              if (state_q == ST_WDATA) begin
                wr_stb_d  = 1'b1;
                wr_addr_d = ptr_q;
                wr_data_d = shift_d;
                ptr_d     = ptr_q + 1'b1;
              end
            end
          end
        end
        ST_RDATA: bit_cnt_d = bit_cnt_q + 4'd1;
        // Advance on the master ACK rise so rd_data is settled by the fall
        ST_RDATA_MACK: begin
          if (!sda_s) ptr_d = ptr_q + 1'b1;
          else        state_d = ST_IGNORE;
        end
        default: ;
      endcase
    end else if (scl_fall) begin
      case (state_q)
        ST_ADDR, ST_SUB, ST_WDATA: begin
          if (bit_cnt_q == BYTE_DONE) begin
            bit_cnt_d = '0;
            sda_oe_d  = 1'b1;
            if (state_q == ST_ADDR) begin
              if (addr_hit) begin
                state_d = ST_ADDR_ACK;
                rw_d    = shift_q[RW_BIT];
                busy_d  = 1'b1;
              end else begin
                state_d  = ST_IGNORE;
                sda_oe_d = 1'b0;
              end
            end else if (state_q == ST_SUB) begin
              state_d = ST_SUB_ACK;
            end else begin
              state_d = ST_WDATA_ACK;
            end
          end
        end
        ST_ADDR_ACK, ST_RDATA_MACK: begin
          if (state_q == ST_RDATA_MACK || rw_q) begin
            state_d   = ST_RDATA;
            shift_d   = rd_data;
            sda_oe_d  = ~rd_data[7];
            bit_cnt_d = '0;
          end else begin
            state_d  = ST_SUB;
            sda_oe_d = 1'b0;
          end
        end
        ST_SUB_ACK, ST_WDATA_ACK: begin
          state_d  = ST_WDATA;
          sda_oe_d = 1'b0;
        end
        ST_RDATA: begin
          if (bit_cnt_q == BYTE_DONE) begin
            state_d   = ST_RDATA_MACK;
            sda_oe_d  = 1'b0;
            bit_cnt_d = '0;
          end else begin
            shift_d  = {shift_q[6:0], 1'b0};
            sda_oe_d = ~shift_q[6];
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      ptr_q     <= '0;
      rw_q      <= 1'b0;
      sda_oe_q  <= 1'b0;
      busy_q    <= 1'b0;
      wr_stb_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      ptr_q     <= ptr_d;
      rw_q      <= rw_d;
      sda_oe_q  <= sda_oe_d;
      busy_q    <= busy_d;
      wr_stb_q  <= wr_stb_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign sda_oe  = sda_oe_q;
  assign wr_stb  = wr_stb_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign rd_addr = ptr_q;
  assign busy    = busy_q;

endmodule

// File: doc/i2c_target_regs.md
# i2c_target_regs

Parametrised I2C target (slave) that bridges an I2C bus to a byte-wide register port owned by the surrounding design. It supports a configurable 7-bit device address and register count, sub-address auto-increment with wrap-around, repeated START, and multi-byte reads and writes. It sits between the uio pads (SDA/SCL) and the design's configuration and status registers, in the dice top level and in later projects.

## Interface
- `DEV_ADDR`, default 7'h70: 7-bit device address (write byte 0xE0, read byte 0xE1).
- `NREGS`, default 8: number of registers. Must be a power of two, 2..256.
- `AW`, default $clog2(NREGS): register pointer width. Derived; do not override.
- `clk` input, 1: system clock. Must run at least 20× SCL.
- `rst_n` input, 1: asynchronous, active-low reset.
- `scl_i` input, 1: raw SCL from pad.
- `sda_i` input, 1: raw SDA from pad.
- `sda_oe` output, 1: 1 = pull SDA low; 0 = release. SDA output data is tied 0 outside the block.
- `wr_stb` output, 1: one-cycle write strobe.
- `wr_addr` output, AW: write register index, valid with `wr_stb`.
- `wr_data` output, 8: write data, valid with `wr_stb`.
- `rd_addr` output, AW: read register index. The host returns `rd_data` combinationally.
- `rd_data` input, 8: register contents at `rd_addr`.
- `busy` output, 1: high from an addressed START (address match ACKed) until STOP.

## Operation
- Input conditioning: 2-FF synchroniser on SCL and SDA, plus one history stage. Edges and conditions are derived from the synchronised pair only.
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
  - SCL rise and SCL fall are detected as single-cycle events.
- Data is sampled on SCL rise, MSB first. `sda_oe` changes only on SCL fall, except in the STOP/START release rule below.
- States:
  - IDLE
  - ADDR: 8 bits.
  - ADDR_ACK
  - SUB: 8 bits.
  - SUB_ACK
  - WDATA
  - WDATA_ACK
  - RDATA: 8 bits driven.
  - RDATA_MACK: master ACK/NACK sampled.
  - IGNORE
- START from any state → ADDR, bit counter cleared. A repeated START keeps the pointer.
- STOP from any state → IDLE, `sda_oe`=0.
- ADDR complete:
  - addr[7:1]==DEV_ADDR → ADDR_ACK (drive low for the 9th clock).
  - Otherwise → IGNORE: release the bus and wait for START/STOP. General call (0x00) is NACKed.
- ADDR_ACK → SUB if R/W=0. If R/W=1, `rd_data` at the pointer is loaded into the shift register at the ACK SCL fall, then → RDATA.
- SUB complete: pointer ← sub[AW-1:0] (upper bits ignored); ACK; → WDATA.
- WDATA complete: `wr_stb` pulses with `wr_addr`=pointer and `wr_data`=byte; pointer increments; ACK; → WDATA.
- RDATA_MACK:
  - ACK (SDA low) → pointer increments, next byte loaded at the SCL fall, → RDATA.
  - NACK → IGNORE.
- Pointer wraps NREGS-1 → 0 on both read and write.
- `rd_addr` always equals the pointer.

## Timing
- Reset values: `sda_oe`=0, `wr_stb`=0, `wr_addr`=0, `wr_data`=0, pointer=0, `busy`=0, state IDLE.
- Edge detection latency: 3 clk after the pad change (2 sync + 1 history).
- `wr_stb` asserts exactly 1 clk, on the cycle after the 8th data-bit SCL rise is detected. The pointer increments in the same cycle.
- ACK `sda_oe` asserts on the SCL fall after the 8th bit and deasserts on the next SCL fall.
- Read bit n is driven from the SCL fall preceding its SCL rise. `rd_data` is captured in the same clk as that SCL fall.
- START or STOP detected while `sda_oe`=1 (protocol error): release on the same cycle and follow the state rule.
- Reset asserted mid-transfer: immediate bus release. No `wr_stb` is emitted for a partial byte.
- A byte interrupted by START/STOP is discarded and produces no strobe.

## Structure
- Shared package `i2c_pkg`:
  - State enum `i2c_state_t`.
  - Constants for read/write bit position and the general-call address.
- Sub-module `i2c_cond_detect`: synchroniser plus START/STOP/SCL-rise/SCL-fall event generation. It is reusable by a future I2C controller.
- The FSM, shift register, bit counter and pointer live in `i2c_target_regs`.

## Test plan
- Write E0, 00, AA, 55, STOP → `wr_stb` at (0,0xAA) then (1,0x55). Four ACKs, `busy` falls after STOP.
- Write E0, 00, 69, 96; then read E0, 00, Sr, E1 for 8 bytes with host regs = 0x69, 0x96, 0..5 → bytes returned in order. Final master NACK releases SDA.
- NREGS=4: write sub 0x03 with 4 bytes → `wr_addr` sequence 3, 0, 1, 2. Read sub 0x06 → starts at index 2.
- Address 0xC0 and general call 0x00 → no ACK, `sda_oe` never asserted, no `wr_stb`, `busy` stays 0.
- STOP after 4 bits of a data byte → no `wr_stb`, state IDLE. A following valid write works.
- Reset pulse during the RDATA drive-low bit → `sda_oe`=0 asynchronously. After reset, a full write transaction succeeds.
